// File: rtl/branch_resolve_unit.sv
// Branch resolution and fetch PC ownership: decodes ALU flags for branch
// opcodes, redirects the PC on taken branches and squashes younger work.
module branch_resolve_unit #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter logic [15:0] PC_STEP      = 16'd2,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  inst_id,
  input  logic [15:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_pos,
  input  logic        alu_valid,
  input  logic [15:0] br_pc,
  input  logic [15:0] imm,
  input  logic        stall,
  output logic [15:0] pc,
  output logic        redirect,
  output logic        flush,
  output logic        zero_q,
  output logic        pos_q,
  output logic [15:0] taken_cnt,
  output logic        state_dbg
);

  typedef enum logic {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

  localparam logic [3:0] OP_BEQ = 4'b1100;
  localparam logic [3:0] OP_BNE = 4'b1101;
  localparam logic [3:0] OP_BGT = 4'b1110;
  localparam logic [3:0] OP_JR  = 4'b1111;
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [15:0] pc_n, taken_cnt_n, target;
  logic        redirect_n, flush_n, zero_n, pos_n;
  logic        cond_met, br_taken;

  // Handshake: alu_valid qualifies inst_id and the flags for one cycle; there
  // is no back-pressure, and anything presented during FLUSH is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      pc        <= RESET_PC;
      redirect  <= 1'b0;
      flush     <= 1'b0;
      zero_q    <= 1'b0;
      pos_q     <= 1'b0;
      taken_cnt <= 16'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pc        <= pc_n;
      redirect  <= redirect_n;
      flush     <= flush_n;
      zero_q    <= zero_n;
      pos_q     <= pos_n;
      taken_cnt <= taken_cnt_n;
    end
  end

  always_comb begin
    cond_met = 1'b0;
    target   = br_pc + imm;
    case (inst_id)
      OP_BEQ:  cond_met = alu_zero;
      OP_BNE:  cond_met = ~alu_zero;
      OP_BGT:  cond_met = alu_pos & ~alu_zero;
      OP_JR:   begin
        cond_met = 1'b1;
        target   = alu_out;
      end
      default: cond_met = 1'b0;
    endcase
    br_taken = alu_valid && (state == ST_IDLE) && cond_met;
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pc_n        = pc;
    redirect_n  = 1'b0;
    flush_n     = flush;
    zero_n      = zero_q;
    pos_n       = pos_q;
    taken_cnt_n = taken_cnt;
    case (state)
      ST_IDLE: begin
        if (alu_valid) begin
          zero_n = alu_zero;
          pos_n  = alu_pos;
        end
        // A taken branch redirects even while stalled.
        if (br_taken) begin
          pc_n        = target;
          redirect_n  = 1'b1;
          flush_n     = 1'b1;
          cnt_n       = FLUSH_INIT;
          state_n     = ST_FLUSH;
          taken_cnt_n = taken_cnt + 16'd1;
        end else if (!stall) begin
          pc_n = pc + PC_STEP;
        end
      end
      ST_FLUSH: begin
        if (!stall) begin
          pc_n = pc + PC_STEP;
          if (cnt == 4'd0) begin
            state_n = ST_IDLE;
            flush_n = 1'b0;
          end else begin
            cnt_n = cnt - 4'd1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    state_dbg = state;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer of the ALU result flags: takes the ALU's opcode, result and zero/pos flags, decides whether a branch is taken, and owns the 16-bit program counter.
- On a taken branch it loads the target, pulses a redirect and squashes in-flight instructions with a timed flush.
- Sits between the ALU stage and the fetch stage of the 16-bit processor.

Parameters:
- RESET_PC, 16'h0000, PC value after reset.
- PC_STEP, 16'd2, sequential PC increment per advancing cycle.
- FLUSH_CYCLES, 2, number of squash cycles after a taken branch; legal range 1..15, held in a 4-bit counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
- inst_id  input  4  opcode of the instruction currently in the ALU stage.
- alu_out  input  16  ALU result; used for the jump-register target only.
- alu_zero  input  1  ALU zero flag for the current instruction.
- alu_pos  input  1  ALU positive flag for the current instruction.
- alu_valid  input  1  inst_id and the ALU flags are valid this cycle.
- br_pc  input  16  PC of the instruction in the ALU stage.
- imm  input  16  signed branch offset.
- stall  input  1  pipeline stall from downstream.
- pc  output  16  current fetch PC (registered).
- redirect  output  1  one-cycle pulse, high in the cycle pc first shows a branch target.
- flush  output  1  squash in-flight fetch/decode instructions.
- zero_q  output  1  registered copy of the last valid alu_zero.
- pos_q  output  1  registered copy of the last valid alu_pos.
- taken_cnt  output  16  count of taken branches; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (reset = 0, async):
  - pc = RESET_PC.
  - redirect, flush, zero_q, pos_q = 0; taken_cnt = 0.
  - State = IDLE, flush counter = 0.
  - Reset asserted mid-flush aborts the flush immediately.
- States: IDLE, FLUSH.
- Branch opcodes (decoded only when alu_valid = 1 in IDLE):
  - 4'b1100 BEQ: taken if alu_zero = 1.
  - 4'b1101 BNE: taken if alu_zero = 0.
  - 4'b1110 BGT: taken if alu_pos = 1 and alu_zero = 0.
  - 4'b1111 JR: always taken; target = alu_out.
  - All other opcodes are non-branch and only update the flag registers.
- Branch target:
  - BEQ/BNE/BGT: target = br_pc + imm, 16-bit modulo, carry discarded.
  - JR: target = alu_out.
- Flag registers: on any edge with alu_valid = 1 in IDLE, zero_q <= alu_zero and pos_q <= alu_pos. Flags are not updated in FLUSH.
- IDLE, taken branch at an edge:
  - pc <= target.
  - redirect <= 1 for exactly one cycle.
  - flush <= 1, counter <= FLUSH_CYCLES - 1, state <= FLUSH.
  - taken_cnt <= taken_cnt + 1.
  - Priority: taken-branch redirect overrides stall.
- IDLE, no taken branch: if stall = 0 then pc <= pc + PC_STEP (wraps modulo 2^16); if stall = 1, pc holds.
- FLUSH:
  - alu_valid and inst_id are ignored; squashed ops never branch or update flags.
  - flush stays 1 and redirect returns to 0.
  - If stall = 0: pc <= pc + PC_STEP. If counter = 0, go to IDLE and clear flush on that edge; otherwise decrement the counter.
  - If stall = 1: pc and counter hold; flush stays 1.
- Result: with no stalls, flush is high for exactly FLUSH_CYCLES cycles starting with the redirect cycle.
- Latency: branch decision to pc update is 1 clock edge; all outputs are registered and there is no combinational path from input to output.
- Next edge after the flush completes: a new branch with alu_valid = 1 is accepted normally.

Test Plan:
- Reset then 4 edges, stall = 0 -> pc = 0000, 0002, 0004, 0006, 0008; flush = 0; taken_cnt = 0.
- At pc = 0008: BEQ, alu_zero = 1, br_pc = 0004, imm = 0010 -> next cycle pc = 0014, redirect = 1; flush high 2 cycles; pc = 0016 then 0018; taken_cnt = 1.
- BNE with alu_zero = 1 -> not taken; pc keeps incrementing; zero_q = 1; redirect = 0.
- BGT with alu_pos = 1, alu_zero = 0, br_pc = 0002, imm = FFFE -> pc = 0000, redirect = 1. During the following flush, drive alu_valid with JR, alu_out = 1234 -> ignored; pc does not become 1234; taken_cnt increments by 1 only.
- Taken JR (alu_out = ABCD) with stall = 1 the same cycle -> pc = ABCD (redirect wins). Hold stall = 1 for 3 cycles -> flush stays 1 and pc holds. Release stall -> flush clears after FLUSH_CYCLES more advancing edges.
- Drive reset = 0 asynchronously in the middle of a FLUSH -> pc = 0000, flush = 0, redirect = 0, and taken_cnt = 0 immediately, without a clock edge. Separately, force taken_cnt to FFFF and take a branch -> taken_cnt = 0000.
